// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - run-mode FSM, execute latency counter and pipeline register update codes
//
// Parameters:
//   NSTAGE  number of pipeline boundary registers (2..8), 0 = fetch/decode side
//   HZ_IDX  register that takes the bubble on hazard/redirect (1..NSTAGE-1)
//   LAT_W   width of ex_wait and the latency counter
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start_req             host start pulse
//   load_done, load_ack   program load complete / ack byte sent (both needed to enter EXEC)
//   stop_in               stop instruction at execute
//   ex_wait[LAT_W]        extra cycles the current execute instruction needs
//   ex_busy               execute unit busy
//   hazard, redirect      decode data hazard / execute-resolved control transfer
//   mode[2]               0 IDLE, 1 LOAD, 2 EXEC, 3 STOP
//   update[2*NSTAGE]      per-register code: 00 hold, 01 advance, 10 clear/bubble
//   ex_done               execute completes this cycle (combinational)
//   ex_start              ex_done registered (EXEC only)
//   lat[LAT_W]            latency counter
// Optional build macro PIPE_CTRL_PERF_CNT_EN adds cyc_cnt, ret_cnt, stall_cnt (32 bit each).
module pipe_ctrl #(
  parameter int NSTAGE = 3,
  parameter int HZ_IDX = 1,
  parameter int LAT_W  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_req,
  input  logic                  load_done,
  input  logic                  load_ack,
  input  logic                  stop_in,
  input  logic [LAT_W-1:0]      ex_wait,
  input  logic                  ex_busy,
  input  logic                  hazard,
  input  logic                  redirect,
  output logic [1:0]            mode,
  output logic [2*NSTAGE-1:0]   update,
  output logic                  ex_done,
  output logic                  ex_start,
  output logic [LAT_W-1:0]      lat
`ifdef PIPE_CTRL_PERF_CNT_EN
  ,
  output logic [31:0]           cyc_cnt,
  output logic [31:0]           ret_cnt,
  output logic [31:0]           stall_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_EXEC = 2'd2,
    S_STOP = 2'd3
  } state_t;

  localparam logic [1:0]       UPD_HOLD = 2'b00;
  localparam logic [1:0]       UPD_ADV  = 2'b01;
  localparam logic [1:0]       UPD_CLR  = 2'b10;
  localparam logic [LAT_W-1:0] LAT_ONE  = {{(LAT_W-1){1'b0}}, 1'b1};

  state_t state, state_nxt;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_req)             state_nxt = S_LOAD;
      S_LOAD:  if (load_done && load_ack) state_nxt = S_EXEC;
      S_EXEC:  if (stop_in)               state_nxt = S_STOP;
      S_STOP:  if (start_req)             state_nxt = S_IDLE;
      default:                            state_nxt = S_IDLE;
    endcase
  end

  assign mode    = state;
  assign ex_done = (lat == ex_wait) && !ex_busy;

  // lat saturates at ex_wait; if ex_wait drops below lat it simply holds
  // until the instruction (and its ex_wait) changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat      <= '0;
      ex_start <= 1'b0;
    end else begin
      ex_start <= 1'b0;
      case (state)
        S_EXEC: begin
          ex_start <= ex_done;
          if (ex_done)             lat <= '0;
          else if (lat < ex_wait)  lat <= lat + LAT_ONE;
        end
        S_STOP: if (start_req)     lat <= '0;
        default: ;
      endcase
    end
  end

  // Redirect flushes everything younger than HZ_IDX except register 0, which
  // advances to load the redirected fetch. Hazard freezes the front end and
  // drops a bubble into HZ_IDX; redirect takes precedence below HZ_IDX.
  always_comb begin
    update = '0;
    for (int i = 0; i < NSTAGE; i++) begin
      if (state != S_EXEC)       update[2*i +: 2] = UPD_CLR;
      else if (!ex_done)         update[2*i +: 2] = UPD_HOLD;
      else if (i < HZ_IDX) begin
        if (redirect)            update[2*i +: 2] = (i == 0) ? UPD_ADV : UPD_CLR;
        else if (hazard)         update[2*i +: 2] = UPD_HOLD;
        else                     update[2*i +: 2] = UPD_ADV;
      end
      else if (i == HZ_IDX)      update[2*i +: 2] = (hazard || redirect) ? UPD_CLR : UPD_ADV;
      else                       update[2*i +: 2] = UPD_ADV;
    end
  end

`ifdef PIPE_CTRL_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || (state == S_IDLE && start_req)) begin
      cyc_cnt   <= '0;
      ret_cnt   <= '0;
      stall_cnt <= '0;
    end else if (state == S_EXEC) begin
      cyc_cnt <= cyc_cnt + 32'd1;
      if (ex_done)                        ret_cnt   <= ret_cnt + 32'd1;
      if (ex_done && hazard && !redirect) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - self-checking bench for pipe_ctrl (NSTAGE=3/HZ_IDX=1 and NSTAGE=4/HZ_IDX=2)
module tb_pipe_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start_req, load_done, load_ack, stop_in, ex_busy, hazard, redirect;
  logic [4:0] ex_wait;

  logic [1:0] mode3, mode4;
  logic [5:0] update3;
  logic [7:0] update4;
  logic       ex_done3, ex_done4, ex_start3, ex_start4;
  logic [4:0] lat3, lat4;
`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [31:0] cyc3, ret3, stall3, cyc4, ret4, stall4;
`endif

  pipe_ctrl #(.NSTAGE(3), .HZ_IDX(1), .LAT_W(5)) dut3 (
    .clk(clk), .rst(rst), .start_req(start_req), .load_done(load_done), .load_ack(load_ack),
    .stop_in(stop_in), .ex_wait(ex_wait), .ex_busy(ex_busy), .hazard(hazard), .redirect(redirect),
    .mode(mode3), .update(update3), .ex_done(ex_done3), .ex_start(ex_start3), .lat(lat3)
`ifdef PIPE_CTRL_PERF_CNT_EN
    , .cyc_cnt(cyc3), .ret_cnt(ret3), .stall_cnt(stall3)
`endif
  );

  pipe_ctrl #(.NSTAGE(4), .HZ_IDX(2), .LAT_W(5)) dut4 (
    .clk(clk), .rst(rst), .start_req(start_req), .load_done(load_done), .load_ack(load_ack),
    .stop_in(stop_in), .ex_wait(ex_wait), .ex_busy(ex_busy), .hazard(hazard), .redirect(redirect),
    .mode(mode4), .update(update4), .ex_done(ex_done4), .ex_start(ex_start4), .lat(lat4)
`ifdef PIPE_CTRL_PERF_CNT_EN
    , .cyc_cnt(cyc4), .ret_cnt(ret4), .stall_cnt(stall4)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference update codes straight from the per-register rules.
  function automatic logic [15:0] exp_upd(int n, int hz, int md, bit done, bit hzd, bit red);
    logic [15:0] r;
    int c;
    r = '0;
    for (int i = 0; i < n; i++) begin
      if (md != 2)       c = 2;
      else if (!done)    c = 0;
      else if (i > hz)   c = 1;
      else if (i == hz)  c = (hzd || red) ? 2 : 1;
      else if (red)      c = (i == 0) ? 1 : 2;
      else if (hzd)      c = 0;
      else               c = 1;
      r[2*i +: 2] = 2'(c);
    end
    return r;
  endfunction

  // Behavioural model: mode as an integer, lat as an integer count.
  int  m_mode = 0;
  int  m_lat  = 0;
  bit  m_exs  = 0;
  bit  chk_en = 0;
  logic m_done;
  assign m_done = (m_lat == int'(ex_wait)) && !ex_busy;
`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [31:0] m_cyc = 0, m_ret = 0, m_stall = 0;
`endif

  always @(posedge clk) begin
    if (rst) begin
      chk_en <= 1;
      m_mode <= 0;
      m_lat  <= 0;
      m_exs  <= 0;
    end else begin
      m_exs <= (m_mode == 2) && m_done;
      case (m_mode)
        0: if (start_req) m_mode <= 1;
        1: if (load_done && load_ack) m_mode <= 2;
        2: begin
          if (m_done)                     m_lat <= 0;
          else if (m_lat < int'(ex_wait)) m_lat <= m_lat + 1;
          if (stop_in) m_mode <= 3;
        end
        default: if (start_req) begin m_mode <= 0; m_lat <= 0; end
      endcase
    end
`ifdef PIPE_CTRL_PERF_CNT_EN
    if (rst || (m_mode == 0 && start_req)) begin
      m_cyc <= 0; m_ret <= 0; m_stall <= 0;
    end else if (m_mode == 2) begin
      m_cyc <= m_cyc + 1;
      if (m_done) m_ret <= m_ret + 1;
      if (m_done && hazard && !redirect) m_stall <= m_stall + 1;
    end
`endif
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("mode3",     mode3,     64'(m_mode));
      check("lat3",      lat3,      64'(m_lat));
      check("ex_start3", ex_start3, 64'(m_exs));
      check("ex_done3",  ex_done3,  64'(m_done));
      check("update3",   update3,   64'(exp_upd(3, 1, m_mode, m_done, hazard, redirect)));
      check("mode4",     mode4,     64'(m_mode));
      check("lat4",      lat4,      64'(m_lat));
      check("ex_done4",  ex_done4,  64'(m_done));
      check("update4",   update4,   64'(exp_upd(4, 2, m_mode, m_done, hazard, redirect)));
`ifdef PIPE_CTRL_PERF_CNT_EN
      check("cyc_cnt",   cyc3,   64'(m_cyc));
      check("ret_cnt",   ret3,   64'(m_ret));
      check("stall_cnt", stall3, 64'(m_stall));
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; start_req = 0; load_done = 0; load_ack = 0; stop_in = 0;
    ex_wait = 0; ex_busy = 0; hazard = 0; redirect = 0;
    step(); step();
    #1;
    check("rst_mode",     mode3,     64'd0);
    check("rst_lat",      lat3,      64'd0);
    check("rst_ex_start", ex_start3, 64'd0);
    check("rst_update3",  update3,   64'b101010);
    check("rst_update4",  update4,   64'b10101010);

    rst = 0; start_req = 1;
    step();
    start_req = 0; load_done = 1; load_ack = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("load_wait_mode",   mode3,   64'd1);
      check("load_wait_update", update3, 64'b101010);
      step();
    end
    load_ack = 1; ex_wait = 3;
    #1 check("ack_cycle_mode", mode3, 64'd1);
    step();
    load_done = 0; load_ack = 0;
    #1 check("exec_entry_mode", mode3, 64'd2);

    for (int k = 0; k < 4; k++) begin
      check("lat_count",    lat3,     64'(k));
      check("lat_ex_done",  ex_done3, 64'(k == 3));
      if (k == 3) check("lat_done_update", update3, 64'b010101);
      step();
      #1;
    end
    check("ex_start_after", ex_start3, 64'd1);
    check("lat_cleared",    lat3,      64'd0);

    ex_wait = 0; ex_busy = 1;
    for (int k = 0; k < 4; k++) begin
      #1 check("busy_hold", update3, 64'b000000);
      step();
    end
    ex_busy = 0;
    #1 check("busy_release", update3, 64'b010101);
    step();

    hazard = 1;
    #1;
    check("hazard3", update3, 64'b011000);
    check("hazard4", update4, 64'b01100000);
    redirect = 1;
    #1;
    check("haz_red3", update3, 64'b011001);
    check("haz_red4", update4, 64'b01101001);
    step();
    hazard = 0;
    #1;
    check("redirect3", update3, 64'b011001);
    check("redirect4", update4, 64'b01101001);
    redirect = 0;
    step();

    stop_in = 1;
    #1;
    check("stop_cycle_update", update3, 64'b010101);
    check("stop_cycle_mode",   mode3,   64'd2);
    step();
    stop_in = 0; ex_wait = 7;
    #1;
    check("stop_mode",   mode3,   64'd3);
    check("stop_update", update3, 64'b101010);
    for (int k = 0; k < 3; k++) begin
      step();
      check("stop_lat_frozen", lat3, 64'd0);
    end
    start_req = 1;
    step();
    start_req = 0;
    #1;
    check("restart_mode", mode3, 64'd0);
    check("restart_lat",  lat3,  64'd0);
    start_req = 1;
    step();
    start_req = 0;
    #1 check("second_start_mode", mode3, 64'd1);

    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 199) == 0);
      start_req = ($urandom_range(0, 7) == 0);
      load_done = 1'($urandom_range(0, 1));
      load_ack  = ($urandom_range(0, 2) == 0);
      stop_in   = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 3) == 0) ex_wait = 5'($urandom_range(0, 5));
      ex_busy   = ($urandom_range(0, 4) == 0);
      hazard    = ($urandom_range(0, 3) == 0);
      redirect  = ($urandom_range(0, 3) == 0);
      step();
    end
    rst = 0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Parametrised pipeline sequencer for the in-order core: owns the run-mode FSM (IDLE/LOAD/EXEC/STOP), the multi-cycle execute latency counter, and per-boundary pipeline-register update codes.
- Generalises the fixed 3-register (F/D, D/E, E/W) control to NSTAGE boundary registers with a configurable hazard-insertion point.
- Adds restart from STOP.
- Sits beside the fetch/decode/execute datapath in the top level and drives each pipeline register's update input.

Parameters:
- NSTAGE, 3, number of pipeline boundary registers; index 0 = fetch/decode, NSTAGE-1 = writeback side; legal range 2..8.
- HZ_IDX, 1, index of the register that receives the bubble on hazard/redirect; 1 <= HZ_IDX <= NSTAGE-1.
- LAT_W, 5, width of the execute wait-time and latency counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start_req  in  1  host start pulse (0xAA received)
- load_done  in  1  program load complete
- load_ack  in  1  ack byte transmitted
- stop_in  in  1  stop instruction at execute stage
- ex_wait  in  LAT_W  extra cycles the current execute instruction needs
- ex_busy  in  1  execute unit busy (UART in progress)
- hazard  in  1  data hazard detected at decode
- redirect  in  1  jump/branch/jr resolved at execute
- mode  out  2  0=IDLE 1=LOAD 2=EXEC 3=STOP
- update  out  2*NSTAGE  update code for register i at bits [2i+1:2i]: 00 hold, 01 advance, 10 clear/bubble
- ex_done  out  1  combinational: execute completes this cycle
- ex_start  out  1  registered ex_done
- lat  out  LAT_W  latency counter

Behaviour:
- Reset (rst=1 at posedge): mode=IDLE, lat=0, ex_start=0. All update outputs then read 10 (non-EXEC mode); ex_done=0 while ex_wait≠0 or ex_busy=1.
- FSM transitions:
  - IDLE->LOAD on start_req.
  - LOAD->EXEC when load_done && load_ack in the same cycle.
  - EXEC->STOP on stop_in.
  - STOP->IDLE on start_req; lat and ex_start are cleared on that transition.
  - All other cases: stay.
- Reset mid-operation returns to IDLE regardless of state.
- ex_done = (lat == ex_wait) && !ex_busy. It is evaluated in every mode, but only has an effect in EXEC.
- Latency counter, in EXEC only:
  - If ex_done: lat <= 0.
  - Else if lat < ex_wait: lat <= lat+1.
  - Otherwise hold.
  - lat never exceeds ex_wait and never wraps. If ex_wait drops below lat, lat holds until the instruction changes.
- ex_start <= ex_done each EXEC cycle; 0 in other modes.
- Update codes, mode != EXEC: all registers 10.
- Update codes, EXEC with ex_done=0: all registers 00.
- Update codes, EXEC with ex_done=1:
  - i=0: 01 if redirect; 00 if hazard; else 01.
  - 0<i<HZ_IDX: 10 if redirect; 00 if hazard; else 01.
  - i=HZ_IDX: 10 if hazard||redirect; else 01.
  - i>HZ_IDX: 01.
- hazard and redirect together: redirect wins for i<HZ_IDX; register HZ_IDX still bubbles.
- stop_in with ex_done: update codes for that cycle are computed as EXEC; the STOP transition takes effect on the next cycle.

Optional Feature:
- Macro PIPE_CTRL_PERF_CNT_EN.
- When defined, adds outputs:
  - cyc_cnt[31:0]: cycles spent in EXEC.
  - ret_cnt[31:0]: count of ex_done cycles in EXEC.
  - stall_cnt[31:0]: EXEC cycles with ex_done && hazard && !redirect.
- All three counters clear on rst and on the IDLE->LOAD transition, freeze in STOP, and wrap modulo 2^32.
- When undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- rst=1 then start_req; hold load_done=1, load_ack=0 for 5 cycles, then load_ack=1 -> mode 0->1, stays 1 for 5 cycles, becomes 2 the cycle after the ack; update=6'b101010 until EXEC.
- EXEC, ex_wait=3, ex_busy=0 -> lat counts 0,1,2,3; ex_done high on the 4th cycle; ex_start high the cycle after; lat back to 0.
- EXEC, ex_wait=0, ex_busy=1 for 4 cycles -> update=000000 for those cycles; first cycle after ex_busy falls gives update=010101.
- NSTAGE=3, HZ_IDX=1, ex_done=1, hazard=1 -> update=6'b011000. redirect=1 (with or without hazard) -> update=6'b011001.
- NSTAGE=4, HZ_IDX=2, redirect=1 -> update=8'b01101001.
- stop_in with ex_done -> mode=3 next cycle, update=10 on all registers, lat frozen; start_req -> mode=0, lat=0; second start_req -> LOAD.
